assignment_arbiter: RTL and testbench
=====================================

Name: assignment_arbiter

Overview:
Round-robin session arbiter that shares one `assignment` generator between NUM_REQ clients. The generator exposes the start/next method interface. A granted client owns the generator for one session: the arbiter issues the start call itself, then forwards the client's next calls until the session ends. The block sits between the client ports and the generator instance, inside the test wrapper layer.

Parameters:
NUM_REQ, 2, number of requesting clients (2..8)
K_W, 1, width of the next argument (next_k)
D_W, 1, width of the next return value
MAX_NEXT, 16, maximum next calls per session before forced release
TIMEOUT, 32, idle cycles in SERVE with no next call before preemption

Ports:
CLK  in  1  clock; all logic on the rising edge
RST  in  1  reset, synchronous, active-high
req  in  NUM_REQ  per-client session request; level held for the whole session
grant  out  NUM_REQ  one-hot owner indication
EN_next_c  in  NUM_REQ  per-client next call enable
next_k_c  in  NUM_REQ*K_W  per-client next argument; client i in slice [i*K_W +: K_W]
RDY_next_c  out  NUM_REQ  per-client next ready
next_c  out  D_W  next return value, broadcast to all clients; valid only for the granted client
preempt  out  NUM_REQ  one-cycle pulse to the client whose session ended by TIMEOUT
dut_EN_start  out  1  start enable to the generator
dut_RDY_start  in  1  start ready from the generator
dut_EN_next  out  1  next enable to the generator
dut_next_k  out  K_W  next argument to the generator
dut_next  in  D_W  next return value from the generator
dut_RDY_next  in  1  next ready from the generator

Behaviour:
- Reset and outputs:
  - Registers after reset: state=IDLE, rr_ptr=0, gidx=0, cnt=0, idle=0.
  - grant=0 and preempt=0 after reset.
  - dut_EN_start, dut_EN_next and all of RDY_next_c are gated low whenever RST=1.
  - Reset in any state aborts the session immediately. No EN pulse is issued in that cycle.
- Method rule: an EN output is never asserted unless its matching dut RDY input is high in the same cycle. Enables are combinational from state and RDY.
- IDLE:
  - If req≠0, capture gidx = first set req bit searching from rr_ptr upward, wrapping modulo NUM_REQ. Go to LAUNCH.
  - grant is registered and becomes one-hot at gidx in the LAUNCH cycle.
- LAUNCH:
  - dut_EN_start = dut_RDY_start. When it fires, clear cnt and idle, then go to SERVE.
  - If req[gidx]=0 in LAUNCH, go to RELEASE without firing start. The drop takes priority over a ready start.
  - Minimum latency is req seen in IDLE → start fired 1 cycle later.
- SERVE:
  - RDY_next_c[gidx] = dut_RDY_next. All other RDY_next_c bits are 0.
  - dut_EN_next = EN_next_c[gidx] & dut_RDY_next.
  - dut_next_k = slice gidx of next_k_c, muxed combinationally.
  - next_c = dut_next, combinational, same cycle as the fire.
  - EN_next_c from non-granted clients is ignored.
  - On a fire: cnt+1 and idle cleared. Otherwise idle+1, saturating.
- Exit from SERVE to RELEASE, checked each cycle after the fire accounting:
  - req[gidx]=0;
  - or cnt reaches MAX_NEXT;
  - or idle reaches TIMEOUT.
  - A fire in the same cycle as the req drop still completes and is counted.
  - The fire that makes cnt=MAX_NEXT completes; release happens the next cycle.
- RELEASE:
  - Lasts exactly one cycle, with grant=0.
  - rr_ptr = (gidx+1) mod NUM_REQ.
  - preempt[gidx] pulses only if the exit cause was TIMEOUT.
  - Next state is IDLE.
- Fairness: with all clients requesting continuously, grants rotate 0,1,…,NUM_REQ-1,0.
- Widths: cnt is clog2(MAX_NEXT+1) bits and idle is clog2(TIMEOUT+1) bits. Neither wraps.

Test Plan:
1. Single client: RST for 2 cycles, then req=01, dut_RDY_start=1 → grant=01 in the next cycle and dut_EN_start pulses once. Then 3 EN_next_c[0] calls with next_k=1 → 3 dut_EN_next pulses with dut_next_k=1. Drop req → RELEASE, grant=00, rr_ptr=1.
2. Round-robin: req=11 held, each client makes 2 calls then drops and re-raises req → grant sequence 01,10,01,10. No cycle ever has two grant bits set.
3. MAX_NEXT=16: client 1 calls next every cycle → exactly 16 dut_EN_next pulses, then grant drops with no further RDY_next_c[1]. The next grant goes to client 0 if it is requesting.
4. TIMEOUT=32: granted client 0 holds req but never calls next → after 32 idle cycles, preempt[0] pulses for 1 cycle and grant=00.
5. Handshake gating: dut_RDY_start=0 for 5 cycles in LAUNCH → dut_EN_start stays 0 and then pulses in the first cycle RDY_start=1. In SERVE with dut_RDY_next=0, EN_next_c=1 → dut_EN_next=0 and RDY_next_c=0.
6. Reset mid-session: assert RST during SERVE after 4 calls → next cycle has state IDLE, grant=0, rr_ptr=0, and no EN pulses while RST=1.

Source files
------------

// File: rtl/assignment_arbiter.sv
// Round-robin session arbiter: one client at a time owns a start/next generator.
// The arbiter issues start itself, then forwards the owner's next calls until release.
module assignment_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned K_W      = 1,
  parameter int unsigned D_W      = 1,
  parameter int unsigned MAX_NEXT = 16,
  parameter int unsigned TIMEOUT  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       grant,
  input  logic [NUM_REQ-1:0]       EN_next_c,
  input  logic [NUM_REQ*K_W-1:0]   next_k_c,
  output logic [NUM_REQ-1:0]       RDY_next_c,
  output logic [D_W-1:0]           next_c,
  output logic [NUM_REQ-1:0]       preempt,
  output logic                     dut_EN_start,
  input  logic                     dut_RDY_start,
  output logic                     dut_EN_next,
  output logic [K_W-1:0]           dut_next_k,
  input  logic [D_W-1:0]           dut_next,
  input  logic                     dut_RDY_next
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_NEXT + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
  localparam logic [IDX_W:0]     NREQ     = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST     = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_NEXT);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0]  IDLE_ONE = IDLE_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {StIdle, StLaunch, StServe, StRelease} state_e;

  state_e              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    gidx;
  logic [CNT_W-1:0]    cnt;
  logic [IDLE_W-1:0]   idle;

  logic [K_W-1:0]      k_arr [NUM_REQ];
  logic [2*NUM_REQ-1:0] req_rot;
  logic [IDX_W:0]      offset;
  logic [IDX_W:0]      pick_sum;
  logic [IDX_W-1:0]    pick;
  logic                req_own;
  logic                serving;
  logic                fire;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [IDLE_W-1:0]   idle_nxt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_k
    assign k_arr[g] = next_k_c[g*K_W +: K_W];
  end

  // Rotate so rr_ptr sits at bit 0; the lowest set bit is the next owner.
  always_comb begin
    req_rot = {req, req} >> rr_ptr;
    offset  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = (IDX_W + 1)'(i);
    end
    pick_sum = {1'b0, rr_ptr} + offset;
    pick     = (pick_sum >= NREQ) ? IDX_W'(pick_sum - NREQ) : pick_sum[IDX_W-1:0];
  end

  assign req_own      = req[gidx];
  assign serving      = !RST && (state == StServe);
  assign fire         = serving && EN_next_c[gidx] && dut_RDY_next;
  assign dut_EN_next  = fire;
  assign dut_EN_start = !RST && (state == StLaunch) && req_own && dut_RDY_start;
  assign RDY_next_c   = (serving && dut_RDY_next) ? (ONE << gidx) : '0;
  assign dut_next_k   = k_arr[gidx];
  assign next_c       = dut_next;

  always_comb begin
    cnt_nxt  = fire ? cnt + CNT_ONE : cnt;
    idle_nxt = fire ? '0 : ((idle == IDLE_MAX) ? idle : idle + IDLE_ONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= StIdle;
      rr_ptr  <= '0;
      gidx    <= '0;
      cnt     <= '0;
      idle    <= '0;
      grant   <= '0;
      preempt <= '0;
    end else begin
      case (state)
        StIdle: begin
          preempt <= '0;
          if (|req) begin
            gidx  <= pick;
            grant <= ONE << pick;
            state <= StLaunch;
          end
        end
        StLaunch: begin
          if (!req_own) begin
            grant <= '0;
            state <= StRelease;
          end else if (dut_RDY_start) begin
            cnt   <= '0;
            idle  <= '0;
            state <= StServe;
          end
        end
        StServe: begin
          cnt  <= cnt_nxt;
          idle <= idle_nxt;
          if (!req_own || (cnt_nxt == CNT_MAX) || (idle_nxt == IDLE_MAX)) begin
            grant   <= '0;
            // A request drop outranks an idle timeout as the exit cause.
            preempt <= (req_own && (cnt_nxt != CNT_MAX) && (idle_nxt == IDLE_MAX)) ?
                       (ONE << gidx) : '0;
            state   <= StRelease;
          end
        end
        StRelease: begin
          preempt <= '0;
          rr_ptr  <= (gidx == LAST) ? '0 : gidx + IDX_ONE;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_assignment_arbiter.sv
// Randomized bench for assignment_arbiter against a session-level reference model.
module tb_assignment_arbiter;

  localparam int N    = 3;
  localparam int KW   = 2;
  localparam int DW   = 3;
  localparam int MAXN = 16;
  localparam int TO   = 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N-1:0]    EN_next_c;
  logic [N*KW-1:0] next_k_c;
  logic [N-1:0]    RDY_next_c;
  logic [DW-1:0]   next_c;
  logic [N-1:0]    preempt;
  logic            dut_EN_start;
  logic            dut_RDY_start;
  logic            dut_EN_next;
  logic [KW-1:0]   dut_next_k;
  logic [DW-1:0]   dut_next;
  logic            dut_RDY_next;

  always #5 CLK = ~CLK;

  assignment_arbiter #(
    .NUM_REQ (N),
    .K_W     (KW),
    .D_W     (DW),
    .MAX_NEXT(MAXN),
    .TIMEOUT (TO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req          (req),
    .grant        (grant),
    .EN_next_c    (EN_next_c),
    .next_k_c     (next_k_c),
    .RDY_next_c   (RDY_next_c),
    .next_c       (next_c),
    .preempt      (preempt),
    .dut_EN_start (dut_EN_start),
    .dut_RDY_start(dut_RDY_start),
    .dut_EN_next  (dut_EN_next),
    .dut_next_k   (dut_next_k),
    .dut_next     (dut_next),
    .dut_RDY_next (dut_RDY_next)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Session-level model: who owns the generator, whether start happened, usage counters.
  bit           busy;
  bit           started;
  bit           cooling;
  int           own;
  int           ptr;
  int           calls;
  int           quiet;
  logic [N-1:0] m_grant;
  logic [N-1:0] m_preempt;
  int           n_sessions;
  int           n_timeouts;

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    busy      = 0;
    started   = 0;
    cooling   = 0;
    own       = 0;
    ptr       = 0;
    calls     = 0;
    quiet     = 0;
    m_grant   = '0;
    m_preempt = '0;
  endtask

  task automatic end_session(input bit timed_out);
    busy      = 0;
    cooling   = 1;
    m_grant   = '0;
    m_preempt = timed_out ? bit_of(own) : '0;
    n_sessions++;
    if (timed_out) n_timeouts++;
  endtask

  // One clock: drive random inputs, check outputs, advance the model, cross the edge.
  task automatic step(input int p_flip, input int p_en, input int p_rdy_s, input int p_rdy_n,
                      input int p_rst);
    bit           serve_now;
    bit           exp_start;
    bit           exp_next;
    logic [N-1:0] exp_rdy;
    int           f;

    for (int i = 0; i < N; i++) begin
      if ($urandom_range(255) < p_flip) req[i] = ~req[i];
      EN_next_c[i] = ($urandom_range(255) < p_en);
    end
    next_k_c      = (N*KW)'($urandom);
    dut_next      = DW'($urandom);
    dut_RDY_start = ($urandom_range(255) < p_rdy_s);
    dut_RDY_next  = ($urandom_range(255) < p_rdy_n);
    RST           = ($urandom_range(255) < p_rst);
    #1;

    serve_now = busy && started;
    exp_start = !RST && busy && !started && req[own] && dut_RDY_start;
    exp_next  = !RST && serve_now && EN_next_c[own] && dut_RDY_next;
    exp_rdy   = (!RST && serve_now && dut_RDY_next) ? bit_of(own) : '0;

    check_eq("grant", 32'(grant), 32'(m_grant));
    check_eq("preempt", 32'(preempt), 32'(m_preempt));
    check_eq("en_start", 32'(dut_EN_start), 32'(exp_start));
    check_eq("en_next", 32'(dut_EN_next), 32'(exp_next));
    check_eq("rdy_next_c", 32'(RDY_next_c), 32'(exp_rdy));
    check_eq("next_c", 32'(next_c), 32'(dut_next));
    if (serve_now) check_eq("next_k", 32'(dut_next_k), 32'(next_k_c[own*KW +: KW]));

    if (RST) begin
      model_reset();
    end else if (cooling) begin
      cooling   = 0;
      ptr       = (own + 1) % N;
      m_preempt = '0;
    end else if (!busy) begin
      f = first_from(req, ptr);
      if (f >= 0) begin
        own     = f;
        busy    = 1;
        started = 0;
        m_grant = bit_of(f);
      end
    end else if (!started) begin
      if (!req[own]) end_session(0);
      else if (dut_RDY_start) begin
        started = 1;
        calls   = 0;
        quiet   = 0;
      end
    end else begin
      if (exp_next) begin
        calls++;
        quiet = 0;
      end else if (quiet < TO) begin
        quiet++;
      end
      if (!req[own]) end_session(0);
      else if (calls == MAXN) end_session(0);
      else if (quiet == TO) end_session(1);
    end

    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_sessions    = 0;
    n_timeouts    = 0;
    RST           = 1'b1;
    req           = '0;
    EN_next_c     = '0;
    next_k_c      = '0;
    dut_next      = '0;
    dut_RDY_start = 1'b0;
    dut_RDY_next  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();

    // Busy clients: frequent calls drive sessions into the call limit.
    repeat (600) step(4, 220, 200, 230, 0);
    // Silent clients holding req: sessions end by timeout.
    repeat (600) step(1, 0, 200, 200, 0);
    // Mixed traffic with request drops and stalled handshakes.
    repeat (600) step(20, 80, 100, 120, 0);
    // Occasional resets landing in arbitrary states.
    repeat (600) step(16, 120, 160, 160, 4);
    // Everyone requesting continuously: rotation order.
    req = '1;
    repeat (400) step(0, 255, 255, 255, 0);

    if (n_sessions == 0 || n_timeouts == 0)
      check_eq("coverage", 32'(n_sessions > 0 && n_timeouts > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
